// File: rtl/mesh_rsc_ni.sv
// Resource-side network interface for one mesh tile: a TX packetiser feeding the
// switch local input and an RX FIFO draining the switch local output.
module mesh_rsc_ni #(
  parameter int ROW_N        = 3,
  parameter int COL_M        = 3,
  parameter int ROW_CORD     = 0,
  parameter int COL_CORD     = 0,
  parameter int PCKT_DATA_W  = 8,
  parameter int FIFO_DEPTH_W = 3,
  localparam int RW = $clog2(ROW_N),
  localparam int CW = $clog2(COL_M),
  localparam int PW = PCKT_DATA_W + RW + CW
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   tx_valid_i,
  output logic                   tx_ready_o,
  input  logic [RW-1:0]          tx_row_i,
  input  logic [CW-1:0]          tx_col_i,
  input  logic [PCKT_DATA_W-1:0] tx_data_i,
  output logic                   tx_drop_o,
  output logic                   tx_err_o,
  output logic [PW-1:0]          ni_pckt_o,
  output logic                   ni_wren_o,
  input  logic                   noc_full_i,
  input  logic                   noc_ovrflw_i,
  input  logic [PW-1:0]          noc_pckt_i,
  input  logic                   noc_wren_i,
  output logic                   ni_full_o,
  output logic                   ni_ovrflw_o,
  output logic                   rx_valid_o,
  input  logic                   rx_ready_i,
  output logic [PCKT_DATA_W-1:0] rx_data_o,
  output logic                   rx_misroute_o
);

  localparam int DEPTH_N = 2 ** FIFO_DEPTH_W;
  localparam logic [FIFO_DEPTH_W:0] DEPTH    = {1'b1, {FIFO_DEPTH_W{1'b0}}};
  localparam logic [31:0]           ROW_N_U  = ROW_N;
  localparam logic [31:0]           COL_M_U  = COL_M;
  localparam logic [RW-1:0]         OWN_ROW  = RW'(ROW_CORD);
  localparam logic [CW-1:0]         OWN_COL  = CW'(COL_CORD);

  // ---------------- TX ----------------
  typedef enum logic {IDLE, WR} tx_state_e;
  tx_state_e state_q, state_d;

  logic addr_ok, accept;
  assign addr_ok = (32'(tx_row_i) < ROW_N_U) && (32'(tx_col_i) < COL_M_U);
  assign accept  = tx_valid_i & tx_ready_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && addr_ok) state_d = WR;
      WR:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Ready is held low while reset is asserted so every output reads 0 in reset.
  always_comb begin
    tx_ready_o = 1'b0;
    ni_wren_o  = 1'b0;
    case (state_q)
      IDLE:    tx_ready_o = ~noc_full_i & ~rst_i;
      WR:      ni_wren_o  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ni_pckt_o <= '0;
      tx_drop_o <= 1'b0;
      tx_err_o  <= 1'b0;
    end else begin
      if (accept && addr_ok) ni_pckt_o <= {tx_col_i, tx_row_i, tx_data_i};
      tx_drop_o <= accept & ~addr_ok;
      tx_err_o  <= tx_err_o | noc_ovrflw_i;
    end
  end

  // ---------------- RX ----------------
  logic [PCKT_DATA_W-1:0]  mem [DEPTH_N];
  logic [FIFO_DEPTH_W-1:0] wr_ptr, rd_ptr;
  logic [FIFO_DEPTH_W:0]   cnt;
  logic                    own_addr, push, pop, full;

  assign own_addr = (noc_pckt_i[PW-1 -: CW] == OWN_COL) &&
                    (noc_pckt_i[PCKT_DATA_W +: RW] == OWN_ROW);
  assign full     = (cnt == DEPTH);
  assign pop      = rx_valid_o & rx_ready_i;
  // A push into a full FIFO only lands if the head leaves in the same cycle.
  assign push     = noc_wren_i & own_addr & (~full | pop);

  assign ni_full_o  = full;
  assign rx_valid_o = (cnt != '0);
  assign rx_data_o  = rx_valid_o ? mem[rd_ptr] : '0;

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= noc_pckt_i[PCKT_DATA_W-1:0];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      cnt           <= '0;
      ni_ovrflw_o   <= 1'b0;
      rx_misroute_o <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: ;
      endcase
      if (noc_wren_i & own_addr & full & ~pop) ni_ovrflw_o   <= 1'b1;
      if (noc_wren_i & ~own_addr)              rx_misroute_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mesh_rsc_ni.sv
// Directed bench for mesh_rsc_ni at tile (1,1) of a 3x3 mesh with a 4-entry RX FIFO.
module tb_mesh_rsc_ni;
  localparam int DW = 8;
  localparam int PW = 12;

  logic          clk = 1'b0, rst_i = 1'b1;
  logic          tx_valid_i = 0, noc_full_i = 0, noc_ovrflw_i = 0, noc_wren_i = 0, rx_ready_i = 0;
  logic [1:0]    tx_row_i = 0, tx_col_i = 0;
  logic [DW-1:0] tx_data_i = 0;
  logic [PW-1:0] noc_pckt_i = 0;
  logic          tx_ready_o, tx_drop_o, tx_err_o, ni_wren_o, ni_full_o, ni_ovrflw_o;
  logic          rx_valid_o, rx_misroute_o;
  logic [PW-1:0] ni_pckt_o;
  logic [DW-1:0] rx_data_o;

  int total = 0, passed = 0, failed = 0;

  always #5 clk = ~clk;

  mesh_rsc_ni #(.ROW_N(3), .COL_M(3), .ROW_CORD(1), .COL_CORD(1),
                .PCKT_DATA_W(8), .FIFO_DEPTH_W(2)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o), .tx_row_i(tx_row_i), .tx_col_i(tx_col_i),
    .tx_data_i(tx_data_i), .tx_drop_o(tx_drop_o), .tx_err_o(tx_err_o),
    .ni_pckt_o(ni_pckt_o), .ni_wren_o(ni_wren_o), .noc_full_i(noc_full_i), .noc_ovrflw_i(noc_ovrflw_i),
    .noc_pckt_i(noc_pckt_i), .noc_wren_i(noc_wren_i), .ni_full_o(ni_full_o), .ni_ovrflw_o(ni_ovrflw_o),
    .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i), .rx_data_o(rx_data_o), .rx_misroute_o(rx_misroute_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".tx_ready"},    tx_ready_o,    0);
    chk({tag, ".tx_drop"},     tx_drop_o,     0);
    chk({tag, ".tx_err"},      tx_err_o,      0);
    chk({tag, ".ni_pckt"},     ni_pckt_o,     0);
    chk({tag, ".ni_wren"},     ni_wren_o,     0);
    chk({tag, ".ni_full"},     ni_full_o,     0);
    chk({tag, ".ni_ovrflw"},   ni_ovrflw_o,   0);
    chk({tag, ".rx_valid"},    rx_valid_o,    0);
    chk({tag, ".rx_data"},     rx_data_o,     0);
    chk({tag, ".rx_misroute"}, rx_misroute_o, 0);
  endtask

  task automatic push(input logic [PW-1:0] p);
    noc_pckt_i = p;
    noc_wren_i = 1'b1;
    tick();
    noc_wren_i = 1'b0;
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk_zero("rst");
    rst_i = 1'b0;
    #1 chk("rel.tx_ready", tx_ready_o, 1);

    // Basic send: (2,0) 0xA5 -> 0x2A5, then (0,1) 0x3C -> 0x43C two cycles later
    tx_valid_i = 1; tx_row_i = 2; tx_col_i = 0; tx_data_i = 8'hA5;
    tick();
    chk("s1.wren", ni_wren_o, 1);
    chk("s1.pckt", ni_pckt_o, 12'h2A5);
    chk("s1.ready", tx_ready_o, 0);
    tx_row_i = 0; tx_col_i = 1; tx_data_i = 8'h3C;
    tick();
    chk("s1b.wren", ni_wren_o, 0);
    chk("s1b.hold", ni_pckt_o, 12'h2A5);
    chk("s1b.ready", tx_ready_o, 1);
    tick();
    chk("s2.wren", ni_wren_o, 1);
    chk("s2.pckt", ni_pckt_o, 12'h43C);
    tx_valid_i = 0;
    tick();
    chk("s2b.wren", ni_wren_o, 0);

    // Backpressure
    noc_full_i = 1; tx_valid_i = 1; tx_row_i = 1; tx_col_i = 2; tx_data_i = 8'h77;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp.ready", tx_ready_o, 0);
      chk("bp.wren", ni_wren_o, 0);
    end
    noc_full_i = 0;
    #1 chk("bp.rel_ready", tx_ready_o, 1);
    tick();
    chk("bp.wren1", ni_wren_o, 1);
    chk("bp.pckt", ni_pckt_o, 12'h977);
    tx_valid_i = 0;
    tick();

    // Bad address, then switch overflow
    tx_valid_i = 1; tx_row_i = 3; tx_col_i = 0; tx_data_i = 8'h11;
    tick();
    chk("bad.drop", tx_drop_o, 1);
    chk("bad.wren", ni_wren_o, 0);
    chk("bad.pckt", ni_pckt_o, 12'h977);
    tx_valid_i = 0;
    tick();
    chk("bad.drop_end", tx_drop_o, 0);
    chk("bad.wren2", ni_wren_o, 0);
    chk("err.pre", tx_err_o, 0);
    noc_ovrflw_i = 1;
    tick();
    noc_ovrflw_i = 0;
    chk("err.set", tx_err_o, 1);
    tick();
    chk("err.sticky", tx_err_o, 1);

    // RX fill and overflow, tile not reading
    push(12'h501);
    chk("rx.valid1", rx_valid_o, 1);
    chk("rx.data1", rx_data_o, 1);
    push(12'h502); push(12'h503);
    chk("rx.full3", ni_full_o, 0);
    push(12'h504);
    chk("rx.full4", ni_full_o, 1);
    chk("rx.ovf4", ni_ovrflw_o, 0);
    push(12'h505);
    chk("rx.ovf5", ni_ovrflw_o, 1);
    rx_ready_i = 1;
    #1 chk("rx.pop1", rx_data_o, 1);
    tick(); chk("rx.pop2", rx_data_o, 2); chk("rx.full_drop", ni_full_o, 0);
    tick(); chk("rx.pop3", rx_data_o, 3);
    tick(); chk("rx.pop4", rx_data_o, 4);
    tick(); chk("rx.empty", rx_valid_o, 0); chk("rx.empty_data", rx_data_o, 0);
    rx_ready_i = 0;

    // Asynchronous reset mid-run clears sticky flags
    rst_i = 1;
    #1 chk_zero("rst2");
    tick();
    rst_i = 0;

    // Full with concurrent pop: no overflow, 9 read last
    push(12'h501); push(12'h502); push(12'h503); push(12'h504);
    chk("cp.full", ni_full_o, 1);
    rx_ready_i = 1;
    push(12'h509);
    chk("cp.ovf", ni_ovrflw_o, 0);
    chk("cp.full_kept", ni_full_o, 1);
    chk("cp.d2", rx_data_o, 2);
    tick(); chk("cp.d3", rx_data_o, 3);
    tick(); chk("cp.d4", rx_data_o, 4);
    tick(); chk("cp.d9", rx_data_o, 9);
    tick(); chk("cp.empty", rx_valid_o, 0); chk("cp.ovf_end", ni_ovrflw_o, 0);

    // Push and pop together on an empty FIFO keeps the word
    push(12'h5AA);
    chk("ep.valid", rx_valid_o, 1);
    chk("ep.data", rx_data_o, 8'hAA);
    tick(); chk("ep.drained", rx_valid_o, 0);
    rx_ready_i = 0;

    // Misroute: packet for (0,2)
    chk("mr.pre", rx_misroute_o, 0);
    push(12'h855);
    chk("mr.set", rx_misroute_o, 1);
    chk("mr.valid", rx_valid_o, 0);

    // Reset during WR
    tx_valid_i = 1; tx_row_i = 0; tx_col_i = 0; tx_data_i = 8'h42;
    tick();
    chk("rw.wren", ni_wren_o, 1);
    chk("rw.pckt", ni_pckt_o, 12'h042);
    tx_valid_i = 0;
    rst_i = 1;
    #1 chk_zero("rst3");
    tick(); tick();
    rst_i = 0;
    #1 chk("rw.ready", tx_ready_o, 1);
    chk("rw.wren_off", ni_wren_o, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
